// File: rtl/payload_nfa_chain.sv
// -----------------------------------------------------------------------------
// payload_nfa_chain
//
// One linear NFA chain compiled from a PCRE fragment. Every chain state
// consumes one bit of the shared character-class bus. A state marked as a
// self-loop implements `[class]*`: it can stay active on repeated class hits,
// and a byte can pass straight over it when the loop is taken zero times.
// The block sits between the character-class decoder and the rule-result
// aggregator.
//
// The start can be anchored or unanchored. The block reports a sticky
// per-packet match flag, a one-cycle pulse on the first match, and the byte
// offset of the byte that completed that first match.
//
// Build option:
//   PAYLOAD_NFA_MATCH_POS_EN - when defined, the byte counter and the
//                              match_pos capture are built. When undefined,
//                              match_pos is tied to 16'h0000. The timing of
//                              match and match_pulse does not depend on it.
//
// Parameters:
//   NUM_STATES - number of chain states (>= 2)
//   CLASS_W    - width of the character-class bus
//   CLASS_SEL  - NUM_STATES bytes, packed. Byte i is the class bit index
//                consumed by state i.
//   LOOP_MASK  - bit i = 1 makes state i a self-loop. Bits 0 and
//                NUM_STATES-1 must be 0.
//   ANCHORED   - 1: state 0 fires only on the first byte after sod/reset
//                0: state 0 may fire on any byte
//
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset; dominates sod and en
//   sod         in   start of data; synchronous per-packet clear
//   en          in   byte valid; char_class is sampled only when en = 1
//   char_class  in   [CLASS_W-1:0] class membership of the current byte
//   match       out  sticky: a match was found since the last sod
//   match_pulse out  one-cycle pulse on the first match of the packet
//   match_pos   out  [15:0] 0-based offset of the byte completing the
//                    first match
//   state_vec   out  [NUM_STATES-1:0] active-state register (debug)
// -----------------------------------------------------------------------------
module payload_nfa_chain #(
    parameter int                      NUM_STATES = 21,
    parameter int                      CLASS_W    = 66,
    parameter logic [NUM_STATES*8-1:0] CLASS_SEL  = {NUM_STATES{8'd0}},
    parameter logic [NUM_STATES-1:0]   LOOP_MASK  = '0,
    parameter int                      ANCHORED   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sod,
    input  logic                  en,
    input  logic [CLASS_W-1:0]    char_class,
    output logic                  match,
    output logic                  match_pulse,
    output logic [15:0]           match_pos,
    output logic [NUM_STATES-1:0] state_vec
);

    // Active-state register and the "next byte is the first of the packet" flag.
    logic [NUM_STATES-1:0] state_q;
    logic                  first_q;

    // Per-state class hit, feed term and next-state value.
    logic [NUM_STATES-1:0] class_hit;
    logic [NUM_STATES-1:0] feed;
    logic [NUM_STATES-1:0] state_next;

    // The match flag is set on the cycle after the final state goes active.
    // Only the first match of a packet is captured.
    logic                  final_hit;

    assign final_hit = state_q[NUM_STATES-1] & ~match;
    assign state_vec = state_q;

    // -------------------------------------------------------------------------
    // Class selection. The loop scans every bus bit and compares it against
    // the configured index. This avoids indexing the bus with a byte-wide
    // selector that can be wider than the bus address.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in this block gets a default first,
        // so no path can leave a value unassigned and infer a latch.
        class_hit = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            for (int j = 0; j < CLASS_W; j++) begin
                if (CLASS_SEL[i*8 +: 8] == 8'(j)) begin
                    class_hit[i] = char_class[j];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Feed chain:
    //   feed(0) = ANCHORED ? first : 1
    //   feed(i) = s(i-1) | (loop(i-1) & feed(i-1))
    // Carrying the term in a local variable keeps the chain a plain ripple.
    // Otherwise the vector would be read back into itself inside this block.
    // -------------------------------------------------------------------------
    always_comb begin : feed_chain
        logic carry;
        feed  = '0;
        carry = (ANCHORED != 0) ? first_q : 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            feed[i] = carry;
            carry   = state_q[i] | (LOOP_MASK[i] & carry);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state terms:
    //   non-loop state: s <= c & feed
    //   loop state:     s <= c & (s | feed)
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            state_next[i] = class_hit[i] & (feed[i] | (LOOP_MASK[i] & state_q[i]));
        end
    end

    // -------------------------------------------------------------------------
    // Chain state, first-byte flag and match flags.
    // A sod on the same cycle as an active final state wins over it, so the
    // match that would have been reported is dropped.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments. Every
        // register therefore samples the values present before this edge.
        if (!rst_n || sod) begin
            state_q     <= '0;
            first_q     <= 1'b1;
            match       <= 1'b0;
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            if (en) begin
                state_q <= state_next;
                first_q <= 1'b0;
            end
            if (final_hit) begin
                match       <= 1'b1;
                match_pulse <= 1'b1;
            end
        end
    end

`ifdef PAYLOAD_NFA_MATCH_POS_EN
    // -------------------------------------------------------------------------
    // Byte offset tracking. byte_cnt counts accepted bytes and saturates.
    // The match is captured one cycle after the completing byte. By then
    // byte_cnt already includes that byte, so the offset is byte_cnt - 1.
    // Any byte accepted on the capture cycle is not seen yet, because the
    // counter value read here is the pre-edge value.
    // -------------------------------------------------------------------------
    logic [15:0] byte_cnt;
    logic [15:0] match_pos_q;

    always_ff @(posedge clk) begin
        if (!rst_n || sod) begin
            byte_cnt    <= 16'h0000;
            match_pos_q <= 16'h0000;
        end else begin
            if (en && (byte_cnt != 16'hFFFF)) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
            if (final_hit) begin
                match_pos_q <= byte_cnt - 16'd1;
            end
        end
    end

    assign match_pos = match_pos_q;
`else
    assign match_pos = 16'h0000;
`endif

endmodule

// File: tb/tb_payload_nfa_chain.sv
// -----------------------------------------------------------------------------
// tb_payload_nfa_chain
//
// Testbench for payload_nfa_chain. It uses the pattern A B X* C on a 4-bit
// class bus: bit0 = A, bit1 = B, bit2 = X, bit3 = C.
//
// Two instances share all stimulus:
//   dut_anch - ANCHORED = 1
//   dut_free - ANCHORED = 0
//
// The reference model keeps the bytes of the current packet. It answers
// "which pattern prefixes end at byte k" by matching the regular expression
// directly against that byte history.
// -----------------------------------------------------------------------------
module tb_payload_nfa_chain;

`ifdef PAYLOAD_NFA_MATCH_POS_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif

    localparam logic [3:0] CA = 4'b0001;
    localparam logic [3:0] CB = 4'b0010;
    localparam logic [3:0] CX = 4'b0100;
    localparam logic [3:0] CC = 4'b1000;
    localparam logic [3:0] CZ = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sod;
    logic        en;
    logic [3:0]  char_class;

    logic        m_a, p_a, m_f, p_f;
    logic [15:0] pos_a, pos_f;
    logic [3:0]  sv_a, sv_f;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    payload_nfa_chain #(
        .NUM_STATES(4), .CLASS_W(4), .CLASS_SEL({8'd3, 8'd2, 8'd1, 8'd0}),
        .LOOP_MASK(4'b0100), .ANCHORED(1)
    ) dut_anch (
        .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .char_class(char_class),
        .match(m_a), .match_pulse(p_a), .match_pos(pos_a), .state_vec(sv_a)
    );

    payload_nfa_chain #(
        .NUM_STATES(4), .CLASS_W(4), .CLASS_SEL({8'd3, 8'd2, 8'd1, 8'd0}),
        .LOOP_MASK(4'b0100), .ANCHORED(0)
    ) dut_free (
        .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .char_class(char_class),
        .match(m_f), .match_pulse(p_f), .match_pos(pos_f), .state_vec(sv_f)
    );

    // ---------------- reference model ----------------
    logic [3:0] pkt[$];   // bytes accepted since the last sod/reset
    int         fk[2];    // index of the first completing byte, -1 if none
    bit         pm[2];    // expected match flag seen at the previous sample
    logic [3:0] esv[2];   // expected state vector

    function automatic bit has(int k, int b);
        if (k < 0 || k >= pkt.size()) return 1'b0;
        return pkt[k][b];
    endfunction

    // Does a pattern prefix end at byte k? The prefix is selected by st:
    //   st = 0 : "A"
    //   st = 1 : "AB"
    //   st = 2 : "ABX+"
    //   st = 3 : "ABX*C"
    // When anchored, the match must start at byte 0.
    function automatic bit reach(int k, int st, bit anch);
        int m;
        int p0;
        if (st == 0) return has(k, 0) && (!anch || k == 0);
        if (st == 1) return has(k, 1) && has(k - 1, 0) && (!anch || k == 1);
        if (st == 3) begin
            if (!has(k, 3)) return 1'b0;
            m  = k - 1;
            p0 = m;
        end else begin
            m  = k;
            p0 = m - 1;
        end
        // p is the position of B. Bytes p+1 .. m must all carry X.
        for (int p = p0; p >= 1; p--) begin
            if (p + 1 <= m && !has(p + 1, 2)) break;
            if (has(p, 1) && has(p - 1, 0) && (!anch || p == 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        pkt.delete();
        for (int a = 0; a < 2; a++) begin
            fk[a]  = -1;
            pm[a]  = 1'b0;
            esv[a] = 4'b0000;
        end
    endtask

    // One clock cycle: drive the inputs, take the edge, update the model,
    // then compare (optionally) both instances.
    task automatic step(input bit do_rst, input bit do_sod, input bit do_en,
                        input logic [3:0] cls, input bit do_check);
        int         len_prev;
        bit         em;
        bit         ep;
        int         v;
        logic [15:0] epos;
        string      pfx;
        rst_n      = !do_rst;
        sod        = do_sod;
        en         = do_en;
        char_class = cls;
        len_prev   = pkt.size();
        @(posedge clk);
        #1;
        if (do_rst || do_sod) begin
            model_clear();
        end else if (do_en) begin
            pkt.push_back(cls);
            for (int a = 0; a < 2; a++) begin
                for (int st = 0; st < 4; st++) begin
                    esv[a][st] = reach(pkt.size() - 1, st, a == 0);
                end
                if (fk[a] < 0 && esv[a][3]) fk[a] = pkt.size() - 1;
            end
        end
        for (int a = 0; a < 2; a++) begin
            em = !(do_rst || do_sod) && fk[a] >= 0 && fk[a] < len_prev;
            ep = em && !pm[a];
            pm[a] = em;
            v = fk[a] + 1;
            if (v > 65535) v = 65535;
            epos = (POS_EN && em) ? 16'(v - 1) : 16'h0000;
            if (do_check) begin
                pfx = (a == 0) ? "anch" : "free";
                check({pfx, "_state_vec"},   32'((a == 0) ? sv_a  : sv_f),  32'(esv[a]));
                check({pfx, "_match"},       32'((a == 0) ? m_a   : m_f),   32'(em));
                check({pfx, "_match_pulse"}, 32'((a == 0) ? p_a   : p_f),   32'(ep));
                check({pfx, "_match_pos"},   32'((a == 0) ? pos_a : pos_f), 32'(epos));
            end
        end
    endtask

    task automatic send(input logic [3:0] cls);
        step(1'b0, 1'b0, 1'b1, cls, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic start_pkt();
        step(1'b0, 1'b1, 1'b0, CZ, 1'b1);
    endtask

    initial begin
        logic [3:0] q[$];
        int         nx;

        rst_n = 1'b0;
        sod = 1'b0;
        en = 1'b0;
        char_class = CZ;
        model_clear();

        // Reset state
        step(1'b1, 1'b0, 1'b1, CA, 1'b1);
        check("reset_state_vec", 32'(sv_a), 32'h0);
        check("reset_match", 32'(m_a), 32'h0);

        // 1: A B C, loop skipped, pos 2
        start_pkt();
        send(CA); check("s1_sv_after_A", 32'(sv_a), 32'h1);
        send(CB); check("s1_sv_after_B", 32'(sv_a), 32'h2);
        send(CC); check("s1_sv_after_C", 32'(sv_a), 32'h8);
        idle(1);
        check("s1_match", 32'(m_a), 32'h1);
        check("s1_pulse", 32'(p_a), 32'h1);
        check("s1_pos", 32'(pos_a), POS_EN ? 32'd2 : 32'd0);
        idle(2);
        check("s1_pulse_drop", 32'(p_a), 32'h0);

        // 2: A B X X X C with 2-cycle gaps
        start_pkt();
        send(CA); idle(2);
        send(CB); idle(2);
        for (int i = 0; i < 3; i++) begin
            send(CX); idle(2);
            check("s2_loop_bit", 32'(sv_a[2]), 32'h1);
        end
        send(CC); idle(3);
        check("s2_match", 32'(m_a), 32'h1);
        check("s2_pos", 32'(pos_a), POS_EN ? 32'd5 : 32'd0);

        // 3: Z A B C - anchored misses, unanchored matches at 3
        start_pkt();
        send(CZ); send(CA); send(CB); send(CC); idle(2);
        check("s3_anch_match", 32'(m_a), 32'h0);
        check("s3_free_match", 32'(m_f), 32'h1);
        check("s3_free_pos", 32'(pos_f), POS_EN ? 32'd3 : 32'd0);

        // 4: A B C A B C - single pulse, pos stays 2; sod clears
        start_pkt();
        send(CA); send(CB); send(CC); send(CA); send(CB); send(CC); idle(2);
        check("s4_pos", 32'(pos_a), POS_EN ? 32'd2 : 32'd0);
        start_pkt();
        check("s4_sod_clear", 32'(m_a), 32'h0);

        // 5: reset with sod and en while state_vec = 0010
        send(CA); send(CB);
        check("s5_pre_sv", 32'(sv_a), 32'h2);
        step(1'b1, 1'b1, 1'b1, CC, 1'b1);
        check("s5_rst_sv", 32'(sv_a), 32'h0);
        start_pkt();
        send(CA); send(CB); send(CC); idle(2);
        check("s5_match", 32'(m_a), 32'h1);
        check("s5_pos", 32'(pos_a), POS_EN ? 32'd2 : 32'd0);

        // sod on the same cycle the final state is active: no pulse
        start_pkt();
        send(CA); send(CB); send(CC);
        start_pkt();
        idle(2);
        check("sod_beats_match", 32'(m_a), 32'h0);

        // Randomized packets, some with an embedded A B X* C
        for (int pk = 0; pk < 40; pk++) begin
            q.delete();
            for (int i = $urandom_range(0, 3); i > 0; i--) q.push_back(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                q.push_back(CA);
                q.push_back(CB);
                nx = $urandom_range(0, 4);
                for (int i = 0; i < nx; i++) q.push_back(CX | 4'($urandom_range(0, 15) & 4'h9));
                q.push_back(CC);
            end
            for (int i = $urandom_range(0, 8); i > 0; i--) q.push_back(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, 1'b1, CA, 1'b1);
            else start_pkt();
            foreach (q[i]) begin
                send(q[i]);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            idle(2);
        end

        // 6: saturation - 70000 idle bytes then A B C
        start_pkt();
        for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, 1'b1, CZ, (i % 8192) == 0);
        send(CA); send(CB); send(CC); idle(2);
        check("s6_free_match", 32'(m_f), 32'h1);
        check("s6_free_pos", 32'(pos_f), POS_EN ? 32'hFFFE : 32'd0);
        check("s6_anch_match", 32'(m_a), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
